// File: rtl/reg_file_pkg.sv
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared definitions for the multi-port register file: default
//               geometry constants and the clear-FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_file_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;

    // CLEAR walks every register to zero after reset; READY is terminal.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

endpackage

`default_nettype wire

// File: rtl/reg_file_clear_fsm.sv
// ============================================================================
// Module      : reg_file_clear_fsm
// Description : Post-reset clear sequencer. Walks cnt from 0 to NREGS-1,
//               requesting a zero write to register cnt on each edge, then
//               parks in READY until the next reset.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               clr_we          - clear write request (never during rst)
//               clr_addr        - register currently being cleared
//               ready           - registered, high only in READY
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_clear_fsm
    import reg_file_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          ready
);

    localparam logic [AW-1:0] c_last = AW'(NREGS - 1);

    clr_state_t    r_state;
    logic [AW-1:0] r_cnt;
    logic          r_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    // The last register is cleared on the same edge that
                    // enters READY, so ready rises NREGS edges after release.
                    if (r_cnt == c_last) begin
                        r_state <= READY;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + AW'(1);
                    end
                end
                READY: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= CLEAR;
                    r_cnt   <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Gated with rst so nothing is written on a reset edge.
    assign clr_we   = (r_state == CLEAR) && !rst;
    assign clr_addr = r_cnt;
    assign ready    = r_ready;

endmodule

`default_nettype wire

// File: rtl/reg_file_mp.sv
// ============================================================================
// Module      : reg_file_mp
// Description : Register file with two write ports, NRD asynchronous read
//               ports and a debug read port. Register 0 reads as zero. All
//               registers are cleared by a sequencer after reset; reads
//               return zero and writes are ignored until ready.
//               Optional macro REG_FILE_MP_BYPASS_EN forwards same-cycle
//               write data to the read ports (port 1 has priority).
// Ports       : clk, rst        - clock, synchronous active-high reset
//               we[1:0]         - write enable per write port
//               waddr, wdata    - packed per write port (port p at p*AW/p*XLEN)
//               raddr, rdata    - packed per read port
//               ready           - initial clear complete
//               dbg_addr/data   - debug read, never bypassed
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    parameter  int NRD   = NRD_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          we,
    input  logic [2*AW-1:0]     waddr,
    input  logic [2*XLEN-1:0]   wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic                ready,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data
);

    logic [XLEN-1:0] r_regs [NREGS];

    logic            w_clr_we;
    logic [AW-1:0]   w_clr_addr;
    logic            w_ready;
    logic            w_rd_en;
    logic [AW-1:0]   w_wa0;
    logic [AW-1:0]   w_wa1;
    logic [XLEN-1:0] w_wd0;
    logic [XLEN-1:0] w_wd1;

    reg_file_clear_fsm #(
        .NREGS (NREGS)
    ) u_clear_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr),
        .ready    (w_ready)
    );

    assign ready = w_ready;
    assign w_wa0 = waddr[0 +: AW];
    assign w_wa1 = waddr[AW +: AW];
    assign w_wd0 = wdata[0 +: XLEN];
    assign w_wd1 = wdata[XLEN +: XLEN];

    // Outputs are forced to zero during rst as well, since ready only drops
    // on the first reset edge.
    assign w_rd_en = w_ready && !rst;

    // ready=1 implies the sequencer is in READY, so clear and user writes
    // never overlap. Port 1 is assigned last so it wins a same-address tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clr_we) begin
                r_regs[w_clr_addr] <= '0;
            end else if (w_ready) begin
                if (we[0] && (w_wa0 != '0)) begin
                    r_regs[w_wa0] <= w_wd0;
                end
                if (we[1] && (w_wa1 != '0)) begin
                    r_regs[w_wa1] <= w_wd1;
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd
            logic [AW-1:0]   w_ra;
            logic [XLEN-1:0] w_stored;
            logic [XLEN-1:0] w_val;

            assign w_ra     = raddr[k*AW +: AW];
            assign w_stored = (w_ra == '0) ? '0 : r_regs[w_ra];

`ifdef REG_FILE_MP_BYPASS_EN
            always_comb begin
                w_val = w_stored;
                if (we[0] && (w_wa0 == w_ra) && (w_ra != '0)) begin
                    w_val = w_wd0;
                end
                if (we[1] && (w_wa1 == w_ra) && (w_ra != '0)) begin
                    w_val = w_wd1;
                end
            end
`else
            assign w_val = w_stored;
`endif

            assign rdata[k*XLEN +: XLEN] = w_rd_en ? w_val : '0;
        end
    endgenerate

    assign dbg_data = (w_rd_en && (dbg_addr != '0)) ? r_regs[dbg_addr] : '0;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none

module tb_reg_file_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          we;
    logic [2*AW-1:0]     waddr;
    logic [2*XLEN-1:0]   wdata;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic                ready;
    logic [AW-1:0]       dbg_addr;
    logic [XLEN-1:0]     dbg_data;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model: stored values, edges since reset release, ready flag.
    logic [XLEN-1:0] mem [NREGS];
    int              since_rel = 0;
    bit              m_ready   = 1'b0;

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr    (raddr),
        .rdata    (rdata),
        .ready    (ready),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] ra);
        logic [XLEN-1:0] v;
        if (!m_ready || rst) return '0;
        v = (ra == 0) ? '0 : mem[ra];
`ifdef REG_FILE_MP_BYPASS_EN
        if (ra != 0) begin
            if (we[0] && waddr[0 +: AW] == ra) v = wdata[0 +: XLEN];
            if (we[1] && waddr[AW +: AW] == ra) v = wdata[XLEN +: XLEN];
        end
`endif
        return v;
    endfunction

    function automatic logic [XLEN-1:0] exp_dbg(input logic [AW-1:0] a);
        if (!m_ready || rst || a == 0) return '0;
        return mem[a];
    endfunction

    // Model update: after the clear the whole file is zero; before it no
    // write is accepted; afterwards port 0 then port 1 (port 1 wins).
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                since_rel = 0;
                m_ready   = 1'b0;
            end else if (!m_ready) begin
                since_rel++;
                if (since_rel == NREGS) begin
                    m_ready = 1'b1;
                    for (int i = 0; i < NREGS; i++) mem[i] = '0;
                end
            end else begin
                if (we[0] && waddr[0 +: AW] != 0) mem[waddr[0 +: AW]] = wdata[0 +: XLEN];
                if (we[1] && waddr[AW +: AW] != 0) mem[waddr[AW +: AW]] = wdata[XLEN +: XLEN];
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("model_ready", {31'd0, ready}, {31'd0, m_ready});
                for (int k = 0; k < NRD; k++)
                    chk($sformatf("model_rdata%0d", k), rdata[k*XLEN +: XLEN],
                        exp_rd(raddr[k*AW +: AW]));
                chk("model_dbg", dbg_data, exp_dbg(dbg_addr));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (ready === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        we[p] = 1'b1;
        waddr[p*AW +: AW] = a;
        wdata[p*XLEN +: XLEN] = d;
    endtask

    int n;
    logic [XLEN-1:0] old9;

    initial begin
        rst = 1'b1; we = '0; waddr = '0; wdata = '0; raddr = '0; dbg_addr = '0;

        // Reset and clear
        tick();
        chk_en = 1'b1;
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_rdata0", rdata[31:0], 32'd0);
        tick(); tick();
        rst = 1'b0;
        wait_ready(n);
        chk("clear_latency", n, 32);
        for (int i = 0; i < NREGS; i++) begin
            dbg_addr = AW'(i);
            #1;
            chk($sformatf("clear_dbg%0d", i), dbg_data, 32'd0);
        end

        // Basic write / read
        wr(0, 5'd5, 32'hDEADBEEF);
        tick();
        we = '0;
        raddr[0 +: AW] = 5'd5;
        #1;
        chk("write_x5", rdata[31:0], 32'hDEADBEEF);
        wr(0, 5'd0, 32'h1234);
        tick();
        we = '0;
        raddr[0 +: AW] = 5'd0;
        #1;
        chk("write_x0", rdata[31:0], 32'd0);

        // Same-address collision
        wr(0, 5'd7, 32'h11);
        wr(1, 5'd7, 32'h22);
        tick();
        we = '0;
        raddr[AW +: AW] = 5'd7;
        #1;
        chk("collision_x7", rdata[63:32], 32'h22);

        // Bypass behaviour
        wr(0, 5'd9, 32'h0000_0009);
        tick();
        we = '0;
        old9 = 32'h0000_0009;
        raddr[AW +: AW] = 5'd9;
        wr(0, 5'd9, 32'hA5A5A5A5);
        #1;
`ifdef REG_FILE_MP_BYPASS_EN
        chk("bypass_same_cycle", rdata[63:32], 32'hA5A5A5A5);
`else
        chk("nobypass_same_cycle", rdata[63:32], old9);
`endif
        dbg_addr = 5'd9;
        #1;
        chk("dbg_not_bypassed", dbg_data, old9);
        tick();
        we = '0;
        #1;
        chk("bypass_next_cycle", rdata[63:32], 32'hA5A5A5A5);

        // Reset mid-clear
        wr(0, 5'd3, 32'h55);
        tick();
        we = '0;
        raddr[0 +: AW] = 5'd3;
        #1;
        chk("x3_written", rdata[31:0], 32'h55);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("midclear_not_ready", {31'd0, ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr(0, 5'd20, 32'hFF);   // must be ignored throughout the clear
        wait_ready(n);
        we = '0;
        chk("midclear_latency", n, 32);
        raddr[0 +: AW] = 5'd20;
        raddr[AW +: AW] = 5'd3;
        #1;
        chk("clear_write_ignored_x20", rdata[31:0], 32'd0);
        chk("midclear_x3_cleared", rdata[63:32], 32'd0);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst = ($urandom_range(0, 399) == 0);
            we  = 2'($urandom);
            for (int p = 0; p < 2; p++) begin
                waddr[p*AW +: AW]   = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
                wdata[p*XLEN +: XLEN] = $urandom;
            end
            for (int k = 0; k < NRD; k++)
                raddr[k*AW +: AW] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            dbg_addr = AW'($urandom);
        end
        tick();
        rst = 1'b0;
        we  = '0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width.
REQ-002 SHALL have parameter NREGS, default 32: register count, power of two, at least 4; AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2: number of read ports, 1..4.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port we, input, 2 bits: write enable per write port (port 0, port 1).
REQ-007 SHALL have port waddr, input, 2 x AW bits: write address per write port.
REQ-008 SHALL have port wdata, input, 2 x XLEN bits: write data per write port.
REQ-009 SHALL have port raddr, input, NRD x AW bits: read address per read port.
REQ-010 SHALL have port rdata, output, NRD x XLEN bits: read data per read port.
REQ-011 SHALL have port ready, output, 1 bit: initial clear complete.
REQ-012 SHALL have port dbg_addr, input, AW bits: debug read address.
REQ-013 SHALL have port dbg_data, output, XLEN bits: debug read data, combinational, never bypassed.

Function
REQ-014 SHALL read asynchronously: rdata[k] follows raddr[k] in the same cycle, zero latency.
REQ-015 SHALL commit a write at the rising edge following we[p]=1, provided ready=1.
REQ-016 SHALL always read register 0 as zero and SHALL discard writes to address 0.
REQ-017 SHALL resolve two same-cycle writes to the same address so that port 1 wins.
REQ-018 SHALL run a clear FSM with states CLEAR and READY and a counter cnt of AW bits.
REQ-019 SHALL, in CLEAR, write zero to register cnt and increment cnt on each edge; at cnt=NREGS-1 it SHALL go to READY.
REQ-020 SHALL set ready=1 only in READY, so ready rises exactly NREGS edges after rst deasserts.
REQ-021 SHALL ignore we while ready=0 and SHALL drive all rdata and dbg_data to zero while ready=0.
REQ-022 SHALL stay in READY until the next rst; the counter SHALL NOT wrap.

Reset
REQ-023 SHALL, with rst=1 at an edge, force state=CLEAR, cnt=0 and ready=0.
REQ-024 SHALL hold rdata=0 and dbg_data=0 while rst=1.
REQ-025 SHALL restart the clear from register 0 when rst is asserted mid-clear or in READY.
REQ-026 SHALL NOT write registers while rst=1.

Configuration
REQ-027 SHALL define macro REG_FILE_MP_BYPASS_EN to compile the write-to-read bypass.
REQ-028 SHALL, with REG_FILE_MP_BYPASS_EN defined and ready=1, return wdata[p] on rdata[k] when we[p]=1 and waddr[p]=raddr[k]!=0 in the same cycle; port 1 SHALL have priority; dbg_data SHALL be unaffected.
REQ-029 SHALL, with REG_FILE_MP_BYPASS_EN undefined, return the stored value; new data SHALL be visible from the cycle after the write edge.

Structure
REQ-030 SHALL place the state encoding typedef (CLEAR, READY) and default XLEN/NREGS/NRD constants in shared package reg_file_pkg.
REQ-031 SHALL implement the clear FSM and counter in sub-module reg_file_clear_fsm; outputs clr_we, clr_addr, ready.

Verification
REQ-032 SHALL test reset and clear: rst high for 3 cycles, then low -> ready=0 for 32 edges, ready=1 after the 32nd; every register reads 0 via dbg_addr 0..31.
REQ-033 SHALL test basic write/read: write x5=0xDEADBEEF on port 0 -> next cycle rdata[0]=0xDEADBEEF with raddr[0]=5; write x0=0x1234 -> x0 reads 0.
REQ-034 SHALL test a same-address collision: port 0 writes x7=0x11 and port 1 writes x7=0x22 in one cycle -> x7=0x22 afterwards.
REQ-035 SHALL test the bypass: with REG_FILE_MP_BYPASS_EN, write x9=0xA5A5A5A5 while raddr[1]=9 -> rdata[1]=0xA5A5A5A5 in the same cycle; without the macro -> old value that cycle, new value the next.
REQ-036 SHALL test reset mid-clear: rst asserted at cnt=10 after x3=0x55 was written -> clear restarts at 0, ready rises 32 edges after release, x3 reads 0.
REQ-037 SHALL test writes during clear: we=1, waddr=20, wdata=0xFF while ready=0 -> x20 reads 0 after ready.
